// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and hazard unit for the 5-stage pipeline. It sits beside the
// ID/EX register. It produces:
//   - per-operand EX forwarding selects, with MEM taking priority over WB,
//   - the load-use, multi-cycle RAW/WAW and structural stalls,
//   - tracking of one outstanding multi-cycle (mul/div) operation.
//
// Parameters
//   NUM_SRC  source operands per instruction (1..3)
//   REG_W    register address width
//   MC_LAT   multi-cycle unit latency in cycles (>= 2)
//
// Ports
//   clk, reset_n          clock and synchronous active-low reset
//   id_rs, id_rs_used     ID source addresses (operand i at [i*REG_W +: REG_W])
//                         and per-operand "actually read" flags
//   id_rd, id_reg_write   ID destination and its write enable
//   id_is_mc              ID instruction is a multi-cycle op
//   ex_rs                 EX source addresses, packed like id_rs
//   ex_rd/mem_rd/wb_rd    destinations in EX, MEM and WB
//   *_reg_write           matching write enables
//   ex_mem_read           EX instruction is a load
//   mc_start              multi-cycle op issued from EX this cycle
//   fwd_sel               2 bits per operand: 00 regfile, 01 WB, 10 MEM
//   stall, bubble         hold PC/IF-ID and insert an ID/EX NOP (identical)
//   mc_busy, mc_done      op outstanding; pulse in its last busy cycle
//   mc_rd_q               destination of the outstanding op
//   stall_count           saturating stall-cycle counter
//
// Build option
//   FWD_STALL_CNT_EN      when defined, stall_count counts stall cycles;
//                         otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
   parameter int NUM_SRC = 2,
   parameter int REG_W   = 5,
   parameter int MC_LAT  = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_SRC*REG_W-1:0]   id_rs,
   input  logic [NUM_SRC-1:0]         id_rs_used,
   input  logic [REG_W-1:0]           id_rd,
   input  logic                       id_reg_write,
   input  logic                       id_is_mc,
   input  logic [NUM_SRC*REG_W-1:0]   ex_rs,
   input  logic [REG_W-1:0]           ex_rd,
   input  logic [REG_W-1:0]           mem_rd,
   input  logic [REG_W-1:0]           wb_rd,
   input  logic                       ex_reg_write,
   input  logic                       mem_reg_write,
   input  logic                       wb_reg_write,
   input  logic                       ex_mem_read,
   input  logic                       mc_start,
   output logic [NUM_SRC*2-1:0]       fwd_sel,
   output logic                       stall,
   output logic                       bubble,
   output logic                       mc_busy,
   output logic                       mc_done,
   output logic [REG_W-1:0]           mc_rd_q,
   output logic [31:0]                stall_count
);

   localparam int               CNT_W    = $clog2(MC_LAT);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {ST_IDLE, ST_BUSY} mc_state_t;

   mc_state_t        state;
   logic [CNT_W-1:0] cnt;

   logic lu_match;
   logic mc_raw_match;
   logic load_use_haz;
   logic mc_haz;
   logic struct_haz;

   // ---------------------------------------------------------------------------
   // EX forwarding: each operand compares only its own address; x0 never
   // forwards. MEM holds the younger value, so it wins over WB.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: default every output first so no path leaves it unassigned and infers a latch.
      fwd_sel = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (ex_rs[i*REG_W +: REG_W] != '0) begin
            if (mem_reg_write && ex_rs[i*REG_W +: REG_W] == mem_rd)
               fwd_sel[i*2 +: 2] = 2'b10;
            else if (wb_reg_write && ex_rs[i*REG_W +: REG_W] == wb_rd)
               fwd_sel[i*2 +: 2] = 2'b01;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Hazard detection. Only operands the ID instruction really reads count.
   // The MC hazard stays up through the mc_done cycle, because the result is
   // written to the regfile only at the end of that cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      lu_match     = 1'b0;
      mc_raw_match = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (id_rs_used[i] && id_rs[i*REG_W +: REG_W] == ex_rd)
            lu_match = 1'b1;
         if (id_rs_used[i] && id_rs[i*REG_W +: REG_W] == mc_rd_q)
            mc_raw_match = 1'b1;
      end
      load_use_haz = ex_mem_read && ex_reg_write && (ex_rd != '0) && lu_match;
      mc_haz       = mc_busy && (mc_rd_q != '0) &&
                     (mc_raw_match || (id_reg_write && id_rd == mc_rd_q));
      struct_haz   = id_is_mc && mc_busy;
   end

   // The stall is suppressed while reset is asserted.
   assign stall  = reset_n && (load_use_haz || mc_haz || struct_haz);
   assign bubble = stall;

   // ---------------------------------------------------------------------------
   // Multi-cycle tracker. mc_done is registered: it rises when cnt steps to 0.
   // A start request while BUSY, including the mc_done cycle, is ignored.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         mc_done <= 1'b0;
         mc_rd_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               mc_done <= 1'b0;
               if (mc_start) begin
                  state   <= ST_BUSY;
                  cnt     <= CNT_INIT;
                  mc_rd_q <= ex_rd;
               end
            end
            ST_BUSY: begin
               if (cnt == '0) begin
                  state   <= ST_IDLE;
                  mc_done <= 1'b0;
               end else begin
                  cnt     <= cnt - CNT_ONE;
                  mc_done <= (cnt == CNT_ONE);
               end
            end
            default: begin
               state   <= ST_IDLE;
               mc_done <= 1'b0;
            end
         endcase
      end
   end

   assign mc_busy = (state == ST_BUSY);

   // ---------------------------------------------------------------------------
   // Stall-cycle counter, saturating at all ones.
   // ---------------------------------------------------------------------------
`ifdef FWD_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset_n)
         stall_count <= '0;
      else if (stall && stall_count != 32'hFFFF_FFFF)
         stall_count <= stall_count + 32'd1;
   end
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Self-checking bench for fwd_hazard_unit with default parameters.
// The combinational forwarding and hazard cases come from a vector table.
// Expected values are queued when a vector is driven and popped when the
// outputs are sampled. Hand-written sequences cover the multi-cycle tracker,
// reset during an operation, and the stall counter.
// Inputs change on the falling edge. Outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

   localparam int NUM_SRC = 2;
   localparam int REG_W   = 5;
   localparam int MC_LAT  = 4;

`ifdef FWD_STALL_CNT_EN
   localparam logic [31:0] EXP_CNT3 = 32'd3;
`else
   localparam logic [31:0] EXP_CNT3 = 32'd0;
`endif

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic [NUM_SRC*REG_W-1:0] id_rs;
   logic [NUM_SRC-1:0]       id_rs_used;
   logic [REG_W-1:0]         id_rd;
   logic                     id_reg_write;
   logic                     id_is_mc;
   logic [NUM_SRC*REG_W-1:0] ex_rs;
   logic [REG_W-1:0]         ex_rd, mem_rd, wb_rd;
   logic                     ex_reg_write, mem_reg_write, wb_reg_write;
   logic                     ex_mem_read;
   logic                     mc_start;
   logic [NUM_SRC*2-1:0]     fwd_sel;
   logic                     stall, bubble, mc_busy, mc_done;
   logic [REG_W-1:0]         mc_rd_q;
   logic [31:0]              stall_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .REG_W(REG_W), .MC_LAT(MC_LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_is_mc(id_is_mc),
      .ex_rs(ex_rs), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write),
      .wb_reg_write(wb_reg_write), .ex_mem_read(ex_mem_read),
      .mc_start(mc_start), .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble),
      .mc_busy(mc_busy), .mc_done(mc_done), .mc_rd_q(mc_rd_q),
      .stall_count(stall_count)
   );

   typedef struct {
      logic [REG_W-1:0]   id_rs1, id_rs0;
      logic [NUM_SRC-1:0] used;
      logic [REG_W-1:0]   ex_rs1, ex_rs0;
      logic [REG_W-1:0]   ex_rd;
      logic               ex_rw, ex_mr;
      logic [REG_W-1:0]   mem_rd;
      logic               mem_rw;
      logic [REG_W-1:0]   wb_rd;
      logic               wb_rw;
      logic [3:0]         exp_fwd;
      logic               exp_stall;
   } vec_t;

   typedef struct {
      logic [3:0] fwd;
      logic       stall;
   } exp_t;

   vec_t tbl[12];
   exp_t sb[$];

   function automatic vec_t mk(
      input logic [4:0] ir1, input logic [4:0] ir0, input logic [1:0] used,
      input logic [4:0] er1, input logic [4:0] er0,
      input logic [4:0] exd, input logic exw, input logic exm,
      input logic [4:0] md, input logic mw, input logic [4:0] wd, input logic ww,
      input logic [3:0] ef, input logic es);
      vec_t v;
      v.id_rs1 = ir1; v.id_rs0 = ir0; v.used = used;
      v.ex_rs1 = er1; v.ex_rs0 = er0;
      v.ex_rd = exd; v.ex_rw = exw; v.ex_mr = exm;
      v.mem_rd = md; v.mem_rw = mw; v.wb_rd = wd; v.wb_rw = ww;
      v.exp_fwd = ef; v.exp_stall = es;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      id_rs = '0; id_rs_used = '0; id_rd = '0; id_reg_write = 1'b0; id_is_mc = 1'b0;
      ex_rs = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
      ex_reg_write = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
      ex_mem_read = 1'b0; mc_start = 1'b0;
   endtask

   // Issue an op writing x12 while the ID inputs (already set up) depend on x12.
   // Expect busy and stall for MC_LAT cycles, with mc_done only in the last one.
   task automatic run_mc(input string tag);
      ex_rd = 5'd12; mc_start = 1'b1;
      #1;
      check({tag, "_pre_stall"}, stall, 0);
      check({tag, "_pre_busy"}, mc_busy, 0);
      @(posedge clk); @(negedge clk);
      mc_start = 1'b0; ex_rd = '0;
      for (int k = 1; k <= MC_LAT; k++) begin
         if (k > 1) cyc();
         #1;
         check($sformatf("%s_busy_c%0d", tag, k), mc_busy, 1);
         check($sformatf("%s_done_c%0d", tag, k), mc_done, (k == MC_LAT) ? 1 : 0);
         check($sformatf("%s_rdq_c%0d", tag, k), mc_rd_q, 12);
         check($sformatf("%s_stall_c%0d", tag, k), stall, 1);
         check($sformatf("%s_bubble_c%0d", tag, k), bubble, 1);
      end
      cyc(); #1;
      check({tag, "_post_busy"}, mc_busy, 0);
      check({tag, "_post_done"}, mc_done, 0);
      check({tag, "_post_stall"}, stall, 0);
   endtask

   initial begin
      exp_t e;

      // Forwarding vectors (rows 0..4, 11) and load-use vectors (rows 5..10).
      tbl[0]  = mk(0, 0, 2'b00, 6, 5, 0, 0, 0, 5, 1, 6, 1, 4'b0110, 0);
      tbl[1]  = mk(0, 0, 2'b00, 6, 5, 0, 0, 0, 5, 1, 5, 1, 4'b0010, 0);
      tbl[2]  = mk(0, 0, 2'b00, 0, 7, 0, 0, 0, 7, 1, 7, 1, 4'b0010, 0);
      tbl[3]  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 1, 4'b0000, 0);
      tbl[4]  = mk(0, 0, 2'b00, 3, 4, 0, 0, 0, 3, 0, 3, 1, 4'b0100, 0);
      tbl[5]  = mk(0, 9, 2'b01, 0, 0, 9, 1, 1, 0, 0, 0, 0, 4'b0000, 1);
      tbl[6]  = mk(0, 9, 2'b10, 0, 0, 9, 1, 1, 0, 0, 0, 0, 4'b0000, 0);
      tbl[7]  = mk(9, 0, 2'b10, 0, 0, 9, 1, 1, 0, 0, 0, 0, 4'b0000, 1);
      tbl[8]  = mk(0, 0, 2'b01, 0, 0, 0, 1, 1, 0, 0, 0, 0, 4'b0000, 0);
      tbl[9]  = mk(0, 9, 2'b01, 0, 0, 9, 1, 0, 0, 0, 0, 0, 4'b0000, 0);
      tbl[10] = mk(0, 9, 2'b01, 0, 0, 9, 0, 1, 0, 0, 0, 0, 4'b0000, 0);
      tbl[11] = mk(0, 0, 2'b00, 8, 2, 0, 0, 0, 8, 1, 2, 1, 4'b1001, 0);

      clear_inputs();
      reset_n = 1'b0;

      // Reset: load-use inputs active, but stall is held low during reset.
      @(negedge clk);
      id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
      ex_rd = 5'd9; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      cyc(); #1;
      check("rst_stall", stall, 0);
      check("rst_bubble", bubble, 0);
      check("rst_busy", mc_busy, 0);
      check("rst_done", mc_done, 0);
      check("rst_rdq", mc_rd_q, 0);
      check("rst_cnt", stall_count, 0);
      clear_inputs();
      @(negedge clk);
      reset_n = 1'b1;

      // Table-driven combinational vectors.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         clear_inputs();
         id_rs = {tbl[i].id_rs1, tbl[i].id_rs0};
         id_rs_used = tbl[i].used;
         ex_rs = {tbl[i].ex_rs1, tbl[i].ex_rs0};
         ex_rd = tbl[i].ex_rd; ex_reg_write = tbl[i].ex_rw; ex_mem_read = tbl[i].ex_mr;
         mem_rd = tbl[i].mem_rd; mem_reg_write = tbl[i].mem_rw;
         wb_rd = tbl[i].wb_rd; wb_reg_write = tbl[i].wb_rw;
         e.fwd = tbl[i].exp_fwd; e.stall = tbl[i].exp_stall;
         sb.push_back(e);
         #1;
         e = sb.pop_front();
         check($sformatf("vec%0d_fwd", i), fwd_sel, e.fwd);
         check($sformatf("vec%0d_stall", i), stall, e.stall);
         check($sformatf("vec%0d_bubble", i), bubble, e.stall);
      end

      // Multi-cycle RAW on x12.
      @(negedge clk);
      clear_inputs();
      id_rs = {5'd0, 5'd12}; id_rs_used = 2'b01;
      run_mc("mc_raw");

      // Multi-cycle WAW on x12.
      clear_inputs();
      id_rd = 5'd12; id_reg_write = 1'b1;
      run_mc("mc_waw");

      // Structural hazard plus a forced start in the middle of an op.
      clear_inputs();
      id_is_mc = 1'b1;
      ex_rd = 5'd12; mc_start = 1'b1;
      #1 check("st_pre_stall", stall, 0);
      @(posedge clk); @(negedge clk);
      mc_start = 1'b0; ex_rd = '0;
      #1 check("st_c1_stall", stall, 1);
      @(negedge clk);
      ex_rd = 5'd3; mc_start = 1'b1;
      #1 check("st_c2_stall", stall, 1);
      cyc();
      mc_start = 1'b0; ex_rd = '0;
      #1;
      check("st_c3_rdq", mc_rd_q, 12);
      check("st_c3_busy", mc_busy, 1);
      check("st_c3_done", mc_done, 0);
      cyc(); #1;
      check("st_c4_done", mc_done, 1);
      check("st_c4_rdq", mc_rd_q, 12);
      cyc(); #1;
      check("st_c5_busy", mc_busy, 0);
      check("st_c5_stall", stall, 0);

      // Reset in the middle of an op drops it.
      clear_inputs();
      id_rs = {5'd0, 5'd12}; id_rs_used = 2'b01;
      ex_rd = 5'd12; mc_start = 1'b1;
      @(posedge clk); @(negedge clk);
      mc_start = 1'b0; ex_rd = '0;
      #1 check("mr_c1_busy", mc_busy, 1);
      @(negedge clk);
      reset_n = 1'b0;
      #1 check("mr_rst_stall", stall, 0);
      cyc(); #1;
      check("mr_busy", mc_busy, 0);
      check("mr_done", mc_done, 0);
      check("mr_rdq", mc_rd_q, 0);
      check("mr_cnt", stall_count, 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < MC_LAT; k++) begin
         cyc(); #1;
         check($sformatf("mr_after_done%0d", k), mc_done, 0);
         check($sformatf("mr_after_stall%0d", k), stall, 0);
      end
      check("cnt_before", stall_count, 0);

      // Three load-use stall cycles.
      @(negedge clk);
      clear_inputs();
      id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
      ex_rd = 5'd9; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      #1 check("cnt_stall", stall, 1);
      cyc(); cyc(); cyc();
      clear_inputs();
      #1;
      check("cnt_three", stall_count, EXP_CNT3);
      cyc(); #1;
      check("cnt_hold", stall_count, EXP_CNT3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the 5-stage pipeline. It generates per-operand EX-stage forwarding selects for NUM_SRC source operands, with MEM-over-WB priority applied independently to every operand. It also generates load-use and multi-cycle-unit stalls, and tracks one outstanding multi-cycle operation (mul/div) with an internal latency counter. It sits beside the ID/EX register and drives the PC/IF-ID hold, the ID/EX bubble and the EX operand muxes.

## Interface
- NUM_SRC, 2: source operands per instruction (1–3).
- REG_W, 5: register address width.
- MC_LAT, 4: multi-cycle unit latency in cycles (≥2).
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  reset; one clock, reset is synchronous and active-low.
- id_rs  in  NUM_SRC*REG_W  ID-stage source addresses, operand i at [i*REG_W +: REG_W].
- id_rs_used  in  NUM_SRC  operand i actually read by the ID instruction.
- id_rd  in  REG_W  ID destination.
- id_reg_write  in  1  ID instruction writes id_rd.
- id_is_mc  in  1  ID instruction is a multi-cycle op.
- ex_rs  in  NUM_SRC*REG_W  EX-stage source addresses.
- ex_rd, mem_rd, wb_rd  in  REG_W each  destinations in EX, MEM and WB.
- ex_reg_write, mem_reg_write, wb_reg_write  in  1 each  write enables.
- ex_mem_read  in  1  EX instruction is a load.
- mc_start  in  1  multi-cycle op issued from EX this cycle.
- fwd_sel  out  NUM_SRC*2  per-operand select: 2'b00 regfile, 2'b01 WB, 2'b10 MEM; 2'b11 never driven.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  insert NOP into ID/EX; always equal to stall.
- mc_busy  out  1  multi-cycle op outstanding.
- mc_done  out  1  one-cycle pulse in the last busy cycle; result writes the regfile at the end of this cycle.
- mc_rd_q  out  REG_W  latched destination of the outstanding op.
- stall_count  out  32  stall-cycle counter (see Configuration).

## Operation
- Forwarding (combinational, per operand i):
  - 2'b10 if ex_rs[i]≠0, ex_rs[i]==mem_rd and mem_reg_write.
  - Else 2'b01 if ex_rs[i]≠0, ex_rs[i]==wb_rd and wb_reg_write.
  - Else 2'b00.
  - Each operand compares only its own address; there is no cross-operand leakage.
- Load-use hazard: ex_mem_read & ex_reg_write & ex_rd≠0 & any operand i with id_rs_used[i] and id_rs[i]==ex_rd.
- MC hazard, only while mc_busy and mc_rd_q≠0 (stalls through the mc_done cycle inclusive):
  - RAW: any used id_rs[i]==mc_rd_q.
  - WAW: id_reg_write & id_rd==mc_rd_q.
- Structural hazard: id_is_mc & mc_busy.
- stall = bubble = load-use | MC hazard | structural.
- MC tracker states:
  - IDLE → BUSY on mc_start. Latch mc_rd_q=ex_rd and cnt=MC_LAT-1.
  - BUSY: cnt decrements each cycle. mc_done=(cnt==0). Return to IDLE after the cnt==0 cycle.
  - mc_start while BUSY is ignored: state, cnt and mc_rd_q are unchanged.
  - mc_start in the cycle mc_done is high is also ignored. The structural stall prevents this case.
- Reset values: cnt 0, mc_busy 0, mc_done 0, mc_rd_q 0, stall_count 0. Outputs that are combinational on inputs follow their inputs during reset, except that stall and bubble are forced to 0 while reset_n=0.
- Reset mid-operation drops the outstanding op. No mc_done is produced.

## Timing
- fwd_sel, stall and bubble are combinational from inputs and state, with zero latency.
- mc_start sampled at edge T gives mc_busy high for cycles T+1 … T+MC_LAT, with mc_done high only in cycle T+MC_LAT.
- An ID instruction dependent on mc_rd_q advances at the first edge after the mc_done cycle and reads the updated regfile.
- Load-use stall lasts exactly one cycle, since the load moves to MEM and ex_rd changes.

## Configuration
- FWD_STALL_CNT_EN defined: stall_count increments by 1 on every clk edge where stall=1 and reset_n=1. It saturates at 32'hFFFF_FFFF.
- Not defined: no counter logic; stall_count is tied to 0.

## Test plan
- ex_rs={rs2=6,rs1=5}, mem_rd=5/wr=1, wb_rd=6/wr=1 → fwd_sel[1:0]=10, fwd_sel[3:2]=01. Then wb_rd=5 instead → fwd_sel[3:2]=00.
- ex_rs[0]=7, mem_rd=7 and wb_rd=7 both writing → 10. Change to ex_rs[0]=0 with mem_rd=0 writing → 00.
- Load in EX (ex_rd=9, ex_mem_read=1), ID uses rs1=9 → stall=bubble=1 for one cycle. Same case with id_rs_used[0]=0 → stall=0.
- MC_LAT=4, mc_start with ex_rd=12 at edge T → mc_busy high T+1..T+4, mc_done only at T+4. ID reads x12 → stall through T+4 and released at T+5. ID writes x12 → stall over the same window.
- ID mc op while busy → stall. A forced mc_start mid-busy leaves cnt and mc_rd_q unchanged.
- reset_n=0 mid-op for one cycle → mc_busy=0, no mc_done, stall_count=0. With FWD_STALL_CNT_EN, 3 stall cycles → stall_count=3.
